// File: rtl/mux_share_arbiter.sv
// Two-requester arbiter that owns the select of a shared 2:1 mux and
// registers the selected data with a valid flag.
module mux_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter bit USE_RR   = 1'b0,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int            CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          tie_pick_a;

    generate
        if (USE_RR) begin : g_rr
            // last_a resets to 0 (last winner = B) so A takes the first tie
            logic last_a;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                 last_a <= 1'b0;
                else if (state_d == GNT_A)  last_a <= 1'b1;
                else if (state_d == GNT_B)  last_a <= 1'b0;
            end
            assign tie_pick_a = ~last_a;
        end else begin : g_fixed
            assign tie_pick_a = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) state_d = tie_pick_a ? GNT_A : GNT_B;
                else if (req_a)     state_d = GNT_A;
                else if (req_b)     state_d = GNT_B;
            end
            GNT_A: begin
                if (!req_a)
                    state_d = req_b ? GNT_B : IDLE;
                else if (req_b && hold_q == HOLD_LAST)
                    state_d = GNT_B;
                else
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
            end
            GNT_B: begin
                if (!req_b)
                    state_d = req_a ? GNT_A : IDLE;
                else if (req_a && hold_q == HOLD_LAST)
                    state_d = GNT_A;
                else
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign grant_a = (state_q == GNT_A);
    assign grant_b = (state_q == GNT_B);
    assign sel     = grant_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (grant_a || grant_b) out <= sel ? data_a : data_b;
            out_valid <= grant_a | grant_b;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized bench comparing three arbiter configurations against an
// ownership/run-length reference model.
module tb_mux_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;

    logic [2:0] ga, gb, sl, ov;
    logic [7:0] ot [3];

    int n_chk  = 0;
    int n_fail = 0;

    // instance 0: fixed, hold 4; 1: round-robin, hold 4; 2: fixed, hold 1
    int rrp [3] = '{0, 1, 0};
    int mhp [3] = '{4, 4, 1};

    // model: owner 0=none 1=A 2=B, run = cycles owned so far, lastw = last owner
    int         own   [3];
    int         run   [3];
    int         lastw [3];
    logic [7:0] eout  [3];
    logic       ev    [3];

    always #5 clk = ~clk;

    mux_share_arbiter #(.WIDTH(8), .USE_RR(1'b0), .MAX_HOLD(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .grant_a(ga[0]), .grant_b(gb[0]),
        .sel(sl[0]), .out(ot[0]), .out_valid(ov[0]));

    mux_share_arbiter #(.WIDTH(8), .USE_RR(1'b1), .MAX_HOLD(4)) u1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .grant_a(ga[1]), .grant_b(gb[1]),
        .sel(sl[1]), .out(ot[1]), .out_valid(ov[1]));

    mux_share_arbiter #(.WIDTH(8), .USE_RR(1'b0), .MAX_HOLD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .grant_a(ga[2]), .grant_b(gb[2]),
        .sel(sl[2]), .out(ot[2]), .out_valid(ov[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_owner(int cur, int r, int lw, bit ra, bit rb, int rr, int mh);
        bit mine, other;
        if (cur == 0) begin
            if (ra && rb) return (rr != 0) ? ((lw == 1) ? 2 : 1) : 1;
            if (ra) return 1;
            if (rb) return 2;
            return 0;
        end
        mine  = (cur == 1) ? ra : rb;
        other = (cur == 1) ? rb : ra;
        if (!mine)              return other ? 3 - cur : 0;
        if (other && r >= mh)   return 3 - cur;
        return cur;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            own[i] = 0; run[i] = 0; lastw[i] = 2; eout[i] = 8'h00; ev[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int nxt;
        for (int i = 0; i < 3; i++) begin
            if (own[i] != 0) eout[i] = (own[i] == 1) ? data_a : data_b;
            ev[i] = (own[i] != 0);
            nxt = next_owner(own[i], run[i], lastw[i], req_a, req_b, rrp[i], mhp[i]);
            run[i] = (nxt == 0) ? 0 : ((nxt == own[i]) ? run[i] + 1 : 1);
            if (nxt != 0) lastw[i] = nxt;
            own[i] = nxt;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("grant_a[%0d]", i), 32'(ga[i]), 32'(own[i] == 1));
            check($sformatf("grant_b[%0d]", i), 32'(gb[i]), 32'(own[i] == 2));
            check($sformatf("sel[%0d]", i),     32'(sl[i]), 32'(own[i] == 1));
            check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ev[i]));
            check($sformatf("out[%0d]", i),     32'(ot[i]), 32'(eout[i]));
            check($sformatf("onehot[%0d]", i),  32'(ga[i] & gb[i]), 32'(0));
        end
    endtask

    // called at a negedge: drive, let one rising edge happen, check at the next negedge
    task automatic cycle(input bit ra, input bit rb, input logic [7:0] da, input logic [7:0] db);
        req_a = ra; req_b = rb; data_a = da; data_b = db;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // single requester A, long hold with no contender
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 8'h5A, 8'h11);

        // asynchronous reset while A is granted
        req_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_grant_a[%0d]", i), 32'(ga[i]), 32'(0));
            check($sformatf("rst_valid[%0d]", i),   32'(ov[i]), 32'(0));
            check($sformatf("rst_out[%0d]", i),     32'(ot[i]), 32'(0));
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h5A, 8'h11);
        cycle(1'b0, 1'b0, 8'h5A, 8'h11);
        cycle(1'b0, 1'b0, 8'h5A, 8'h11);

        // sustained tie: forced handovers and per-cycle alternation for hold 1
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1, 8'hA5, 8'h3C);
        cycle(1'b0, 1'b0, 8'h00, 8'h00);

        // round-robin tie memory: A alone, idle, tie; B alone, idle, tie
        cycle(1'b1, 1'b0, 8'h01, 8'h02);
        cycle(1'b0, 1'b0, 8'h01, 8'h02);
        cycle(1'b1, 1'b1, 8'h03, 8'h04);
        cycle(1'b0, 1'b0, 8'h03, 8'h04);
        cycle(1'b0, 1'b1, 8'h05, 8'h06);
        cycle(1'b0, 1'b0, 8'h05, 8'h06);
        cycle(1'b1, 1'b1, 8'h07, 8'h08);
        cycle(1'b0, 1'b0, 8'h07, 8'h08);

        // release handover: A granted, B waiting, A drops early
        cycle(1'b1, 1'b0, 8'h10, 8'h20);
        cycle(1'b1, 1'b1, 8'h11, 8'h21);
        cycle(1'b0, 1'b1, 8'h12, 8'h22);
        cycle(1'b0, 1'b1, 8'h13, 8'h23);
        cycle(1'b0, 1'b0, 8'h13, 8'h23);

        // randomized traffic with sticky requests to create contention
        for (int k = 0; k < 400; k++) begin
            bit ra, rb;
            ra = ($urandom_range(0, 3) != 0) ? req_a : ~req_a;
            rb = ($urandom_range(0, 3) != 0) ? req_b : ~req_b;
            cycle(ra, rb, 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
